// File: rtl/fifo_pkg.sv
// Shared FIFO definitions used by the synchronous and asynchronous FIFO controllers.
// Provides:
//   - FIFO_DATA_WIDTH / FIFO_ADDR_WIDTH : default word width (41) and log2 depth (4)
//   - cnt_width()   : width of the occupancy count / binary pointers (ADDR_WIDTH+1)
//   - thresh_ok()   : legality check for almost-full / almost-empty thresholds
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 41;
  localparam int FIFO_ADDR_WIDTH = 4;

  // One extra bit so that a count of DEPTH and pointer wrap at 2*DEPTH are representable.
  function automatic int cnt_width(input int addr_width);
    return addr_width + 1;
  endfunction

  // almost_full threshold must be in 1..DEPTH, almost_empty in 0..DEPTH-1.
  function automatic bit thresh_ok(input int af_thresh, input int ae_thresh, input int depth);
    return (af_thresh >= 1) && (af_thresh <= depth) &&
           (ae_thresh >= 0) && (ae_thresh <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM, DEPTH x DATA_WIDTH, DEPTH = 2**ADDR_WIDTH.
// Ports:
//   clk      in   write clock
//   wr_en    in   write strobe (synchronous write)
//   wr_addr  in   write address
//   wr_data  in   write word
//   rd_addr  in   read address
//   rd_data  out  read word (combinational read)
// Contents are never reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller with occupancy count, programmable almost-full /
// almost-empty thresholds and sticky overflow/underflow flags.
// Compile-time option: define SYNC_FIFO_FWFT_EN for first-word-fall-through reads
// (rd_data shows the head word combinationally, rd_en pops). Undefined: rd_data is
// registered on each accepted read (1-cycle latency) and resets to 0.
// Ports:
//   clk, rst                 single clock, asynchronous active-high reset
//   wr_en, wr_data           write request / word (accepted iff !full)
//   rd_en                    read request / pop (accepted iff !empty)
//   err_clr                  clears overflow/underflow (a same-cycle new error wins)
//   rd_data                  read word
//   full, empty              count == DEPTH / count == 0
//   almost_full/almost_empty count >= AF_THRESH / count <= AE_THRESH
//   count                    occupancy 0..DEPTH
//   overflow, underflow      sticky error flags
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int AF_THRESH  = (2 ** ADDR_WIDTH) - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = cnt_width(ADDR_WIDTH);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  if (!thresh_ok(AF_THRESH, AE_THRESH, DEPTH)) begin : g_bad_thresh
    $error("sync_fifo_ctrl: AF_THRESH must be 1..DEPTH and AE_THRESH 0..DEPTH-1");
  end

  logic [CW-1:0]         wr_ptr;
  logic [CW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] mem_rd;

  // Status flags decode only the registered count.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data (mem_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ONE_C;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + ONE_C;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + ONE_C;
        2'b01:   count_q <= count_q - ONE_C;
        default: count_q <= count_q;
      endcase
    end
  end

  // A fresh error event takes priority over err_clr in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end else if (err_clr) begin
        underflow <= 1'b0;
      end
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rd_data = mem_rd;
`else
  logic [DATA_WIDTH-1:0] rd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= '0;
    end else if (rd_acc) begin
      rd_q <= mem_rd;
    end
  end

  assign rd_data = rd_q;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed self-checking bench for sync_fifo_ctrl (default parameters).
module tb_sync_fifo_ctrl;

  localparam int DW = 41;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic          err_clr;
  logic [DW-1:0] rd_data;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  int tests = 0;
  int fails = 0;

  sync_fifo_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .AF_THRESH  (14),
    .AE_THRESH  (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .err_clr      (err_clr),
    .rd_data      (rd_data),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag, input int c);
    chk({tag, " count"}, 64'(count), 64'(c));
    chk({tag, " full"}, 64'(full), 64'(c == 16));
    chk({tag, " empty"}, 64'(empty), 64'(c == 0));
    chk({tag, " almost_full"}, 64'(almost_full), 64'(c >= 14));
    chk({tag, " almost_empty"}, 64'(almost_empty), 64'(c <= 2));
  endtask

  logic [DW-1:0] val;

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; wr_data = '0;
    step(); step();
    chk_flags("reset", 0);
    chk("reset overflow", 64'(overflow), 64'd0);
    chk("reset underflow", 64'(underflow), 64'd0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("reset rd_data", 64'(rd_data), 64'd0);
`endif
    rst = 1'b0;
    step();

    // Fill with 1..16, then one write while full.
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1'b1; wr_data = DW'(i);
      step();
      chk_flags($sformatf("fill%0d", i), i);
    end
    wr_data = DW'(17);
    step();
    chk("overflow set", 64'(overflow), 64'd1);
    chk_flags("overflow hold", 16);
    wr_en = 1'b0; err_clr = 1'b1;
    step();
    chk("overflow cleared", 64'(overflow), 64'd0);
    err_clr = 1'b0;

    // Drain all 16.
    for (int k = 1; k <= 16; k++) begin
      rd_en = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
      #1 chk($sformatf("drain head%0d", k), 64'(rd_data), 64'(k));
`endif
      step();
`ifndef SYNC_FIFO_FWFT_EN
      chk($sformatf("drain data%0d", k), 64'(rd_data), 64'(k));
`endif
      chk_flags($sformatf("drain%0d", k), 16 - k);
    end
    rd_en = 1'b0;
    step();
    chk("no underflow after drain", 64'(underflow), 64'd0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("rd_data holds", 64'(rd_data), 64'd16);
`endif

    // Prime 8 words, then simultaneous read/write for 40 cycles across pointer wraps.
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = DW'(32'h100 + i);
      step();
    end
    chk("prime count", 64'(count), 64'd8);
    for (int j = 0; j < 40; j++) begin
      wr_en = 1'b1; rd_en = 1'b1; wr_data = DW'(32'h108 + j);
`ifdef SYNC_FIFO_FWFT_EN
      #1 chk($sformatf("stream head%0d", j), 64'(rd_data), 64'(32'h100 + j));
`endif
      step();
`ifndef SYNC_FIFO_FWFT_EN
      chk($sformatf("stream data%0d", j), 64'(rd_data), 64'(32'h100 + j));
`endif
      chk($sformatf("stream count%0d", j), 64'(count), 64'd8);
    end
    wr_en = 1'b0;
    for (int m = 0; m < 8; m++) begin
      rd_en = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
      #1 chk($sformatf("tail head%0d", m), 64'(rd_data), 64'(32'h128 + m));
`endif
      step();
`ifndef SYNC_FIFO_FWFT_EN
      chk($sformatf("tail data%0d", m), 64'(rd_data), 64'(32'h128 + m));
`endif
    end
    rd_en = 1'b0;
    chk_flags("tail end", 0);

    // Both requests while empty: write wins, read rejected.
    wr_en = 1'b1; rd_en = 1'b1; wr_data = DW'(32'hAA);
    step();
    chk_flags("empty both", 1);
    chk("underflow set", 64'(underflow), 64'd1);
    chk("overflow clear", 64'(overflow), 64'd0);
    wr_en = 1'b0;
    step();
    chk_flags("pop AA", 0);
    chk("underflow sticky", 64'(underflow), 64'd1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("rd_data AA", 64'(rd_data), 64'hAA);
`endif
    err_clr = 1'b1;
    step();
    chk("underflow wins over clr", 64'(underflow), 64'd1);
    rd_en = 1'b0;
    step();
    chk("underflow cleared", 64'(underflow), 64'd0);
    err_clr = 1'b0;

    // Asynchronous reset mid-stream with 5 words and an error pending.
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("underflow before rst", 64'(underflow), 64'd1);
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = DW'(32'h200 + i);
      step();
    end
    wr_en = 1'b0;
    chk("count before rst", 64'(count), 64'd5);
    #2 rst = 1'b1;
    #1;
    chk_flags("async rst", 0);
    chk("rst overflow", 64'(overflow), 64'd0);
    chk("rst underflow", 64'(underflow), 64'd0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("rst rd_data", 64'(rd_data), 64'd0);
`endif
    step();
    rst = 1'b0;
    wr_en = 1'b1; wr_data = DW'(32'h300);
    step();
    wr_en = 1'b0; rd_en = 1'b1;
    chk("post rst count", 64'(count), 64'd1);
`ifdef SYNC_FIFO_FWFT_EN
    #1 chk("post rst head", 64'(rd_data), 64'h300);
`endif
    step();
    rd_en = 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
    chk("post rst data", 64'(rd_data), 64'h300);
`endif
    chk_flags("post rst end", 0);

    // Single-word path with a 33-bit-wide value.
    val = 41'h1_2345_6789;
    wr_en = 1'b1; wr_data = val;
    step();
    wr_en = 1'b0;
    chk("wide empty", 64'(empty), 64'd0);
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft head", 64'(rd_data), 64'(val));
`endif
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("wide popped empty", 64'(empty), 64'd1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("wide data", 64'(rd_data), 64'(val));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ctrl.md
# sync_fifo_ctrl

Single-clock, parametrised FIFO controller: the synchronous successor to the bridge's async FIFO, for paths where the AHB-Lite and SPI sides share one clock. Adds a live occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a compile-time first-word-fall-through read mode. It buffers 41-bit bridge transfer words by default and sits between the AHB-Lite slave front end and the SPI master engine.

## Interface
- DATA_WIDTH, 41, word width in bits
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH (16)
- AF_THRESH, DEPTH-2 (14), almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1

Clock and reset are fixed: one clock; reset is asynchronous and active-high.
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write word
- rd_en  in  1  read request
- err_clr  in  1  clears sticky overflow/underflow
- rd_data  out  DATA_WIDTH  read word
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_THRESH
- almost_empty  out  1  count <= AE_THRESH
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- wr_ptr and rd_ptr are ADDR_WIDTH+1-bit binary pointers; the low ADDR_WIDTH bits address memory, and the pointers wrap naturally at 2*DEPTH.
- Write is accepted iff wr_en && !full; the word is stored at wr_ptr and wr_ptr increments.
- Read is accepted iff rd_en && !empty; rd_ptr increments.
- Acceptance is evaluated against the current registered flags:
  - full with wr_en && rd_en: read accepted, write rejected (sets overflow).
  - empty with both: write accepted, read rejected (sets underflow).
- count is registered:
  - +1 on write only; -1 on read only; unchanged on both or neither.
  - Never exceeds DEPTH, never goes below 0.
- All four status flags are combinational decodes of the registered count only; no input feeds them combinationally.
- overflow is set at the edge after wr_en && full; underflow is set at the edge after rd_en && empty.
  - Both are sticky until err_clr.
  - A new error event in the same cycle as err_clr wins, so the flag stays 1.
- Rejected requests change no pointer, count or memory.
- Reset values:
  - pointers 0, count 0
  - empty 1, almost_empty 1
  - full 0, almost_full 0
  - overflow 0, underflow 0
  - rd_data 0 in standard mode
- Reset mid-operation discards all contents immediately, asynchronously. Memory contents are not cleared.
- Illegal AF_THRESH/AE_THRESH values raise an elaboration-time error.

## Timing
- Write to readable: a word written at edge N clears empty from edge N (count updates at N). A read may be accepted at edge N+1.
- Standard read latency is 1: for a read accepted at edge N, rd_data is registered at N and holds that word until the next accepted read.
- Flags, count and error bits all update on the same edge as the causing transfer.
- Full throughput: one write and one read per cycle sustained, with no bubbles at the pointer wrap.

## Configuration
- SYNC_FIFO_FWFT_EN defined:
  - rd_data continuously shows mem[rd_ptr], the head word, with zero read latency.
  - rd_en acts as a pop/acknowledge; the head word is visible once empty = 0.
  - rd_data is don't-care while empty, and is not reset.
- SYNC_FIFO_FWFT_EN undefined: standard registered read as described under Timing.
- Flags, count, errors and acceptance rules are identical in both modes.

## Structure
- Shared package fifo_pkg:
  - default DATA_WIDTH (41) and ADDR_WIDTH (4)
  - the count-width function (ADDR_WIDTH+1)
  - the threshold range-check function
  - these are reused by the async controller.
- Sub-module fifo_mem: simple dual-port RAM, DEPTH x DATA_WIDTH.
  - Synchronous write, combinational read port.
  - The controller registers the read data in standard mode.
- The control logic (pointers, count, flags, errors) lives in sync_fifo_ctrl.

## Test plan
- Reset, then 16 writes of 0x0_0000_0001..0x0_0000_0010 -> count 16; full=1 at the 16th edge; almost_full=1 from count 14; 17th write sets overflow and leaves count 16.
- Read all 16 (standard mode) -> rd_data sequence 0x01..0x10, each one cycle after its accepted read; empty=1 after the last read; almost_empty=1 from count 2.
- With count 8, assert wr_en and rd_en for 40 cycles -> count stays 8, the pointers wrap at least twice, and data order is preserved.
- Empty FIFO, rd_en=1 with wr_en=1 -> write accepted, count 1, underflow=1; then err_clr=1 with a new rd_en-while-empty in the same cycle -> underflow stays 1; a subsequent err_clr alone clears it.
- Assert rst while count=5 mid-stream -> immediately count 0, empty 1, full 0, errors 0; the next write and read return the new data.
- With SYNC_FIFO_FWFT_EN defined, write 0x1_2345_6789 -> rd_data equals 0x1_2345_6789 while empty=0 before any rd_en; rd_en pops it and empty=1 at that edge.
